// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Package : systolic_pkg
// Purpose : Shared types and helpers for the streaming systolic matmul block.
//           FSM state encoding, default operand/accumulator types and the
//           operand extension helper used by every PE.
// Revision: 1.0 - initial release
// ============================================================================
package systolic_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ACC_W_DEF-1:0]  acc_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Bit prepended to an operand to widen it by one bit before the signed
  // multiply: a copy of the MSB in signed mode, zero in unsigned mode.
  function automatic logic mac_ext(input logic msb, input logic is_signed);
    return msb & is_signed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
// Module  : systolic_pe
// Purpose : One output-stationary MAC cell. Each cycle it multiplies the
//           extended operands into its accumulator and forwards a to the
//           right and b downward through one register stage.
// Ports   : clk_i, rst_i    clock, synchronous active-high reset
//           signed_i        1 = operands are two's complement
//           clr_i           clear accumulator (has priority over en_i)
//           en_i            accumulate enable
//           a_i / b_i       operands from the left / above
//           a_o / b_o       registered operands to the right / below
//           acc_o           accumulator (wraps modulo 2^ACC_W)
// Revision: 1.0 - initial release
// ============================================================================
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              signed_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic signed [DATA_W:0] a_x;
  logic signed [DATA_W:0] b_x;
  logic [ACC_W-1:0]       prod;
  logic [DATA_W-1:0]      a_q;
  logic [DATA_W-1:0]      b_q;
  logic [ACC_W-1:0]       acc_q;

  assign a_x = $signed({mac_ext(a_i[DATA_W-1], signed_i), a_i});
  assign b_x = $signed({mac_ext(b_i[DATA_W-1], signed_i), b_i});
  // Operands are sign-extended to the accumulator width first, so the
  // product is already correct modulo 2^ACC_W.
  assign prod = ACC_W'(a_x) * ACC_W'(b_x);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      if (clr_i) begin
        acc_q <= '0;
      end else if (en_i) begin
        acc_q <= acc_q + prod;
      end
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/systolic_matmul_stream.sv
`default_nettype none
// ============================================================================
// Module  : systolic_matmul_stream
// Purpose : C = A*B on a ROWSxCOLS output-stationary int8 MAC array. K beats
//           (column of A + row of B) stream in under valid/ready, the array
//           flushes, then C drains one row per cycle under valid/ready.
// Ports   : i_clk, i_rst          clock, synchronous active-high reset
//           i_start, i_k          run request and reduction depth (IDLE only)
//           i_signed, i_accum     operand mode, keep accumulators
//           i_in_valid/o_in_ready operand beat handshake, i_a / i_b data
//           o_row_valid/i_row_ready result row handshake
//           o_row, o_row_idx, o_row_last  result row, its index, last flag
//           o_busy, o_done        not-idle flag, end-of-run pulse
// Revision: 1.0 - initial release
// ============================================================================
module systolic_matmul_stream
  import systolic_pkg::*;
#(
  parameter  int ROWS   = 16,
  parameter  int COLS   = 16,
  parameter  int DATA_W = 8,
  parameter  int ACC_W  = 32,
  parameter  int KMAX   = 256,
  localparam int KW     = $clog2(KMAX + 1),
  localparam int RW     = $clog2(ROWS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [KW-1:0]                i_k,
  input  logic                         i_signed,
  input  logic                         i_accum,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [ROWS-1:0][DATA_W-1:0]  i_a,
  input  logic [COLS-1:0][DATA_W-1:0]  i_b,
  output logic                         o_row_valid,
  input  logic                         i_row_ready,
  output logic [COLS-1:0][ACC_W-1:0]   o_row,
  output logic [RW-1:0]                o_row_idx,
  output logic                         o_row_last,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int             FW         = $clog2(ROWS + COLS);
  // Flush counter runs FLUSH_LAST..0, i.e. ROWS+COLS-1 cycles.
  localparam logic [FW-1:0]  FLUSH_LAST = FW'(ROWS + COLS - 2);
  localparam logic [RW-1:0]  IDX_LAST   = RW'(ROWS - 1);

  state_t                       state_q;
  logic [KW-1:0]                k_q;
  logic [KW-1:0]                beat_q;
  logic [FW-1:0]                flush_q;
  logic                         signed_q;
  logic                         in_ready_q;
  logic                         row_valid_q;
  logic                         row_last_q;
  logic                         done_q;
  logic [RW-1:0]                row_idx_q;
  logic [COLS-1:0][ACC_W-1:0]   row_q;

  logic                         accept;
  logic                         clr_acc;
  logic                         pe_en;
  logic [RW-1:0]                row_nxt;

  logic [DATA_W-1:0]            a_feed [ROWS];
  logic [DATA_W-1:0]            b_feed [COLS];
  logic [DATA_W-1:0]            a_pe   [ROWS][COLS];
  logic [DATA_W-1:0]            b_pe   [ROWS][COLS];
  logic [COLS-1:0][ACC_W-1:0]   acc_row [ROWS];

  assign accept  = i_in_valid && in_ready_q;
  assign clr_acc = (state_q == S_IDLE) && i_start && (i_k != '0) && !i_accum;
  // Pipeline is all zeros outside a run, so enabling over the whole run is
  // enough; accumulators are frozen in IDLE for a following accumulate run.
  assign pe_en   = (state_q != S_IDLE);
  assign row_nxt = row_idx_q + 1'b1;

  // --------------------------------------------------------------------------
  // Input skew: lane r of A / lane c of B sees r / c extra register stages so
  // that matching operands meet in PE(r,c). Stage 0 captures the accepted
  // beat, or zero on a bubble.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic [DATA_W-1:0] sh_q [r+1];
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int i = 0; i <= r; i++) sh_q[i] <= '0;
      end else begin
        sh_q[0] <= accept ? i_a[r] : '0;
        for (int i = 1; i <= r; i++) sh_q[i] <= sh_q[i-1];
      end
    end
    assign a_feed[r] = sh_q[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic [DATA_W-1:0] sh_q [c+1];
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int i = 0; i <= c; i++) sh_q[i] <= '0;
      end else begin
        sh_q[0] <= accept ? i_b[c] : '0;
        for (int i = 1; i <= c; i++) sh_q[i] <= sh_q[i-1];
      end
    end
    assign b_feed[c] = sh_q[c];
  end

  // --------------------------------------------------------------------------
  // PE array
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_W-1:0] a_in;
      logic [DATA_W-1:0] b_in;
      if (c == 0) begin : g_a_edge
        assign a_in = a_feed[r];
      end else begin : g_a_int
        assign a_in = a_pe[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_in = b_feed[c];
      end else begin : g_b_int
        assign b_in = b_pe[r-1][c];
      end
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .signed_i (signed_q),
        .clr_i    (clr_acc),
        .en_i     (pe_en),
        .a_i      (a_in),
        .b_i      (b_in),
        .a_o      (a_pe[r][c]),
        .b_o      (b_pe[r][c]),
        .acc_o    (acc_row[r][c])
      );
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs. The first DRAIN cycle only loads
  // row 0, which gives the last MAC of the flush time to land.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      flush_q     <= '0;
      signed_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
      done_q      <= 1'b0;
      row_idx_q   <= '0;
      row_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start && (i_k != '0)) begin
            state_q    <= S_LOAD;
            k_q        <= i_k;
            signed_q   <= i_signed;
            beat_q     <= '0;
            in_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (beat_q == k_q - 1'b1) begin
              state_q    <= S_FLUSH;
              in_ready_q <= 1'b0;
              beat_q     <= '0;
              flush_q    <= FLUSH_LAST;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (flush_q == '0) begin
            state_q <= S_DRAIN;
          end else begin
            flush_q <= flush_q - 1'b1;
          end
        end
        S_DRAIN: begin
          if (!row_valid_q) begin
            row_valid_q <= 1'b1;
            row_idx_q   <= '0;
            row_last_q  <= 1'b0;
            row_q       <= acc_row[0];
          end else if (i_row_ready) begin
            if (row_last_q) begin
              state_q     <= S_IDLE;
              row_valid_q <= 1'b0;
              row_last_q  <= 1'b0;
              row_idx_q   <= '0;
              row_q       <= '0;
              done_q      <= 1'b1;
            end else begin
              row_idx_q  <= row_nxt;
              row_last_q <= (row_nxt == IDX_LAST);
              row_q      <= acc_row[row_nxt];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = in_ready_q;
  assign o_row_valid = row_valid_q;
  assign o_row       = row_q;
  assign o_row_idx   = row_idx_q;
  assign o_row_last  = row_last_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;

endmodule
`default_nettype wire
